hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 28 ++
 rtl/hazard_scoreboard_md_busy_counter.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 100 ++++++++++
 tb/tb_hazard_scoreboard.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Constants shared by the decoder and the hazard scoreboard: Tuse/Tnew encodings
// and the default multiply/divide unit latencies.
package hazard_scoreboard_pkg;

    localparam int TW_DEFAULT = 2;

    localparam logic [TW_DEFAULT-1:0] TUSE_NOW    = 2'd0;
    localparam logic [TW_DEFAULT-1:0] TUSE_E      = 2'd1;
    localparam logic [TW_DEFAULT-1:0] TUSE_M      = 2'd2;
    localparam logic [TW_DEFAULT-1:0] TUSE_UNUSED = 2'b11;

    localparam logic [TW_DEFAULT-1:0] TNEW_NONE = 2'd0;
    localparam logic [TW_DEFAULT-1:0] TNEW_ALU  = 2'd1;
    localparam logic [TW_DEFAULT-1:0] TNEW_LOAD = 2'd2;

    localparam int MULT_LAT_DEFAULT = 5;
    localparam int DIV_LAT_DEFAULT  = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width needed to hold the longer of the two MD latencies.
    function automatic int md_cnt_w(input int mult_lat, input int div_lat);
        return $clog2(max_int(mult_lat, div_lat) + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Down-counter tracking how many cycles the multiply/divide unit stays busy.
module md_busy_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int CW = md_cnt_w(MULT_LAT, DIV_LAT);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (start) begin
            cnt_d = is_div ? DIV_LOAD : MULT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard scoreboard: per-register result-latency counters,
// a wildcard counter for late-resolved destinations, and MD unit busy tracking.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          D_valid,
    input  logic [AW-1:0] D_rs,
    input  logic [AW-1:0] D_rt,
    input  logic [TW-1:0] rs_tuse,
    input  logic [TW-1:0] rt_tuse,
    input  logic          D_we,
    input  logic [AW-1:0] D_dst,
    input  logic [TW-1:0] D_tnew,
    input  logic          D_dst_unknown,
    input  logic          D_md_use,
    input  logic          D_md_start,
    input  logic          D_md_div,
    output logic          stall,
    output logic          stall_rs,
    output logic          stall_rt,
    output logic          stall_md,
    output logic          md_busy
);

    logic [TW-1:0] cnt_q [NREG];
    logic [TW-1:0] cnt_d [NREG];
    logic [TW-1:0] wcnt_q;
    logic [TW-1:0] wcnt_d;
    logic [TW-1:0] rs_cnt;
    logic [TW-1:0] rt_cnt;
    logic          issue;
    logic          load_dst;
    logic          load_wild;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
        return (x == '0) ? '0 : x - TW'(1);
    endfunction

    // Register 0 is hardwired, so it never contributes a pending write.
    always_comb begin
        rs_cnt = '0;
        rt_cnt = '0;
        if (D_rs != '0 && int'(D_rs) < NREG) rs_cnt = cnt_q[D_rs];
        if (D_rt != '0 && int'(D_rt) < NREG) rt_cnt = cnt_q[D_rt];
    end

    assign stall_rs = D_valid && (D_rs != '0) && ((rs_cnt > rs_tuse) || (wcnt_q > rs_tuse));
    assign stall_rt = D_valid && (D_rt != '0) && ((rt_cnt > rt_tuse) || (wcnt_q > rt_tuse));
    assign stall_md = D_valid && D_md_use && md_busy;
    assign stall    = stall_rs || stall_rt || stall_md;

    assign issue     = D_valid && !stall;
    assign load_dst  = issue && D_we && !D_dst_unknown && (D_dst != '0);
    assign load_wild = issue && D_we && D_dst_unknown;

    // A load on issue wins over the decrement; flush wins over everything.
    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = sat_dec(cnt_q[r]);
            if (load_dst && int'(D_dst) == r) cnt_d[r] = D_tnew;
            if (flush) cnt_d[r] = '0;
        end
        wcnt_d = sat_dec(wcnt_q);
        if (load_wild) wcnt_d = D_tnew;
        if (flush) wcnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            wcnt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wcnt_q <= wcnt_d;
        end
    end

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .start  (issue && D_md_start),
        .is_div (D_md_div),
        .busy   (md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a per-cycle vector table plus
// hand-written MD latency and reset/flush sequences.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       D_valid;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic [1:0] rs_tuse;
    logic [1:0] rt_tuse;
    logic       D_we;
    logic [4:0] D_dst;
    logic [1:0] D_tnew;
    logic       D_dst_unknown;
    logic       D_md_use;
    logic       D_md_start;
    logic       D_md_div;
    logic       stall;
    logic       stall_rs;
    logic       stall_rt;
    logic       stall_md;
    logic       md_busy;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .D_valid       (D_valid),
        .D_rs          (D_rs),
        .D_rt          (D_rt),
        .rs_tuse       (rs_tuse),
        .rt_tuse       (rt_tuse),
        .D_we          (D_we),
        .D_dst         (D_dst),
        .D_tnew        (D_tnew),
        .D_dst_unknown (D_dst_unknown),
        .D_md_use      (D_md_use),
        .D_md_start    (D_md_start),
        .D_md_div      (D_md_div),
        .stall         (stall),
        .stall_rs      (stall_rs),
        .stall_rt      (stall_rt),
        .stall_md      (stall_md),
        .md_busy       (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       v;
        logic [4:0] rs;
        logic [1:0] rsu;
        logic [4:0] rt;
        logic [1:0] rtu;
        logic       we;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       unk;
        logic [2:0] md;   // {use, start, div}
        logic [4:0] exp;  // {stall, stall_rs, stall_rt, stall_md, md_busy}
    } vec_t;

    localparam logic [1:0] U = TUSE_UNUSED;
    localparam int NV = 30;
    vec_t vt [NV];

    function automatic vec_t V(input string n, input logic v, input logic [4:0] rs,
                               input logic [1:0] rsu, input logic [4:0] rt,
                               input logic [1:0] rtu, input logic we, input logic [4:0] dst,
                               input logic [1:0] tnew, input logic unk,
                               input logic [2:0] md, input logic [4:0] exp);
        vec_t t;
        t.name = n; t.v = v; t.rs = rs; t.rsu = rsu; t.rt = rt; t.rtu = rtu;
        t.we = we; t.dst = dst; t.tnew = tnew; t.unk = unk; t.md = md; t.exp = exp;
        return t;
    endfunction

    task automatic idle();
        reset = 1'b0; flush = 1'b0; D_valid = 1'b0;
        D_rs = '0; D_rt = '0; rs_tuse = U; rt_tuse = U;
        D_we = 1'b0; D_dst = '0; D_tnew = '0; D_dst_unknown = 1'b0;
        D_md_use = 1'b0; D_md_start = 1'b0; D_md_div = 1'b0;
    endtask

    task automatic drive(input vec_t t);
        D_valid = t.v; D_rs = t.rs; rs_tuse = t.rsu; D_rt = t.rt; rt_tuse = t.rtu;
        D_we = t.we; D_dst = t.dst; D_tnew = t.tnew; D_dst_unknown = t.unk;
        D_md_use = t.md[2]; D_md_start = t.md[1]; D_md_div = t.md[0];
    endtask

    task automatic chk(input string nm, input logic [4:0] exp);
        logic [4:0] act;
        act = {stall, stall_rs, stall_rt, stall_md, md_busy};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {stall,rs,rt,md,busy}=%b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Issue an MD op, then hold mflo in D and count the cycles it is held.
    task automatic md_latency(input string nm, input logic is_div, input int exp_cycles);
        int n;
        @(negedge clk);
        idle();
        D_valid = 1'b1; D_md_use = 1'b1; D_md_start = 1'b1; D_md_div = is_div;
        #1 chk({nm, "_start"}, 5'b00000);
        @(negedge clk);
        idle();
        D_valid = 1'b1; D_md_use = 1'b1; D_we = 1'b1; D_dst = 5'd2; D_tnew = TNEW_ALU;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!stall_md) break;
            n++;
            @(negedge clk);
        end
        chk_int({nm, "_stall_cycles"}, n, exp_cycles);
        chk({nm, "_released"}, 5'b00000);
    endtask

    // Divide plus lw $3 in flight, then reset or flush with a same-cycle load attempt.
    task automatic kill_in_flight(input string nm, input logic use_reset);
        @(negedge clk);
        idle();
        D_valid = 1'b1; D_md_use = 1'b1; D_md_start = 1'b1; D_md_div = 1'b1;
        #1 chk({nm, "_div"}, 5'b00000);
        @(negedge clk);
        idle();
        D_valid = 1'b1; D_rs = 5'd1; rs_tuse = TUSE_E;
        D_we = 1'b1; D_dst = 5'd3; D_tnew = TNEW_LOAD;
        #1 chk({nm, "_lw3"}, 5'b00001);
        @(negedge clk);
        idle();
        if (use_reset) reset = 1'b1; else flush = 1'b1;
        D_valid = 1'b1; D_we = 1'b1; D_dst = 5'd3; D_tnew = 2'd3;
        #1 chk({nm, "_cycle"}, 5'b00001);
        @(negedge clk);
        idle();
        D_valid = 1'b1; D_rs = 5'd3; rs_tuse = TUSE_NOW; D_md_use = 1'b1;
        #1 chk({nm, "_after"}, 5'b00000);
    endtask

    initial begin
        vt[0]  = V("reset_state",   0,  0, U,   0, U, 0, 0, 0, 0, 3'b000, 5'b00000);
        vt[1]  = V("lw3_issue",     1,  1, 1,   0, U, 1, 3, 2, 0, 3'b000, 5'b00000);
        vt[2]  = V("add_dep_stall", 1,  3, 1,   5, 1, 1, 4, 1, 0, 3'b000, 5'b11000);
        vt[3]  = V("add_dep_issue", 1,  3, 1,   5, 1, 1, 4, 1, 0, 3'b000, 5'b00000);
        vt[4]  = V("idle",          0,  0, U,   0, U, 0, 0, 0, 0, 3'b000, 5'b00000);
        vt[5]  = V("lw3_again",     1,  1, 1,   0, U, 1, 3, 2, 0, 3'b000, 5'b00000);
        vt[6]  = V("beq_stall1",    1,  3, 0,   0, 0, 0, 0, 0, 0, 3'b000, 5'b11000);
        vt[7]  = V("beq_stall2",    1,  3, 0,   0, 0, 0, 0, 0, 0, 3'b000, 5'b11000);
        vt[8]  = V("beq_issue",     1,  3, 0,   0, 0, 0, 0, 0, 0, 3'b000, 5'b00000);
        vt[9]  = V("lwso_issue",    1,  1, 1,   0, U, 1, 0, 2, 1, 3'b000, 5'b00000);
        vt[10] = V("sw_wild_stall", 1, 29, 1,   7, 2, 0, 0, 0, 0, 3'b000, 5'b11000);
        vt[11] = V("zero_srcs",     1,  0, 0,   0, 0, 0, 0, 0, 0, 3'b000, 5'b00000);
        vt[12] = V("sw_wild_issue", 1, 29, 1,   7, 2, 0, 0, 0, 0, 3'b000, 5'b00000);
        vt[13] = V("w8_tnew2",      1,  0, U,   0, U, 1, 8, 2, 0, 3'b000, 5'b00000);
        vt[14] = V("w8_tnew1",      1,  0, U,   0, U, 1, 8, 1, 0, 3'b000, 5'b00000);
        vt[15] = V("r8_stall",      1,  8, 0,   0, U, 0, 0, 0, 0, 3'b000, 5'b11000);
        vt[16] = V("r8_issue",      1,  8, 0,   0, U, 0, 0, 0, 0, 3'b000, 5'b00000);
        vt[17] = V("w8_tnew3",      1,  0, U,   0, U, 1, 8, 3, 0, 3'b000, 5'b00000);
        vt[18] = V("w8_tnew1b",     1,  0, U,   0, U, 1, 8, 1, 0, 3'b000, 5'b00000);
        vt[19] = V("r8_rt_stall",   1,  8, 1,   8, 0, 0, 0, 0, 0, 3'b000, 5'b10100);
        vt[20] = V("r8_rt_issue",   1,  0, U,   8, 0, 0, 0, 0, 0, 3'b000, 5'b00000);
        vt[21] = V("w0_issue",      1,  0, U,   0, U, 1, 0, 3, 0, 3'b000, 5'b00000);
        vt[22] = V("r0_probe",      1,  0, 0,   0, 0, 0, 0, 0, 0, 3'b000, 5'b00000);
        vt[23] = V("lw3_bubble",    1,  1, 1,   0, U, 1, 3, 2, 0, 3'b000, 5'b00000);
        vt[24] = V("stalled_w9",    1,  3, 0,   0, U, 1, 9, 3, 0, 3'b000, 5'b11000);
        vt[25] = V("r9_probe",      1,  9, 0,   0, U, 0, 0, 0, 0, 3'b000, 5'b00000);
        vt[26] = V("div_issue",     1,  0, U,   0, U, 0, 0, 0, 0, 3'b111, 5'b00000);
        vt[27] = V("busy_other",    1,  0, U,   0, U, 0, 0, 0, 0, 3'b000, 5'b00001);
        vt[28] = V("busy_mduse",    1,  0, U,   0, U, 0, 0, 0, 0, 3'b100, 5'b10011);
        vt[29] = V("busy_invalid",  0,  0, U,   0, U, 0, 0, 0, 0, 3'b100, 5'b00001);

        idle();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            drive(vt[i]);
            #1 chk(vt[i].name, vt[i].exp);
        end

        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        idle();
        #1 chk("post_reset", 5'b00000);

        md_latency("div", 1'b1, DIV_LAT_DEFAULT);
        md_latency("mult", 1'b0, MULT_LAT_DEFAULT);
        kill_in_flight("flush", 1'b0);
        kill_in_flight("reset", 1'b1);

        @(negedge clk);
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
